// File: rtl/ext_mem_port_if.sv
// Token types and the grouped bus of the external-memory port.
// The host/bench side uses the master modport, the memory port uses the slave modport.
package ext_mem_pkg;
    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_EXADDR = 16;

    typedef struct packed {
        logic                    v;
        logic                    a;
        logic                    r;
        logic                    c;
        logic [WIDTH_EXADDR-1:0] i;
        logic [WIDTH_DATA-1:0]   d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

interface ext_mem_port_if;
    logic                                  I_Boot_Start;
    logic                                  O_Boot;
    logic                                  I_Ld_Req;
    logic [ext_mem_pkg::WIDTH_EXADDR-1:0]  I_Ld_Addr;
    ext_mem_pkg::FTk_t                     O_Ld_FTk;
    ext_mem_pkg::BTk_t                     I_Ld_BTk;
    logic                                  I_St_Req;
    logic [ext_mem_pkg::WIDTH_EXADDR-1:0]  I_St_Addr;
    ext_mem_pkg::FTk_t                     I_St_FTk;
    ext_mem_pkg::BTk_t                     O_St_BTk;
    logic                                  I_Pre_We;
    logic [ext_mem_pkg::WIDTH_EXADDR-1:0]  I_Pre_Addr;
    logic [ext_mem_pkg::WIDTH_DATA-1:0]    I_Pre_Data;
    logic                                  O_Err;

    modport slave (
        input  I_Boot_Start, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
        input  I_St_Req, I_St_Addr, I_St_FTk,
        input  I_Pre_We, I_Pre_Addr, I_Pre_Data,
        output O_Boot, O_Ld_FTk, O_St_BTk, O_Err
    );

    modport master (
        output I_Boot_Start, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
        output I_St_Req, I_St_Addr, I_St_FTk,
        output I_Pre_We, I_Pre_Addr, I_Pre_Data,
        input  O_Boot, O_Ld_FTk, O_St_BTk, O_Err
    );
endinterface

// File: rtl/ext_mem_port.sv
// External-memory port: boot token replay, loads with RD_LAT-cycle latency, token-handshake stores.
// Load acceptance gated by I_Ld_BTk.n (in-flight loads never stall); stores nacked on port conflict.
module ext_mem_port
    import ext_mem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int BOOT_PAD   = 3,
    parameter int BOOT_LEN   = 5,
    parameter int RD_LAT     = 1,
    parameter bit EXTEND_MEM = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    ext_mem_port_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW = WIDTH_EXADDR;
    localparam int L  = RD_LAT - 1;
    localparam logic [XW:0]   DEPTH_X   = (XW+1)'(DEPTH);
    localparam logic [XW-1:0] PAD_LAST  = XW'(BOOT_PAD - 1);
    localparam logic [XW-1:0] BOOT_LAST = XW'(BOOT_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_BOOT = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]            state;
    logic [XW-1:0]         cnt;
    logic [RD_LAT-1:0]     p_vld;
    logic [RD_LAT-1:0]     p_oor;
    logic [XW-1:0]         p_addr [RD_LAT];
    logic [WIDTH_DATA-1:0] dq     [RD_LAT];
    logic [WIDTH_DATA-1:0] mem    [DEPTH];
    FTk_t                  tok;
    FTk_t                  tok_nxt;
    BTk_t                  st_btk;
    logic                  err;

    logic                  in_run;
    logic                  pipe_busy;
    logic                  ld_acc;
    logic                  ld_oor;
    logic                  boot_go;
    logic                  st_vld;
    logic                  st_nack;
    logic                  st_ok;
    logic                  st_oor;
    logic                  pre_oor;
    logic                  pre_wr;
    logic                  st_wr;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         wr_idx;
    logic [WIDTH_DATA-1:0] wr_dat;
    logic                  unused_fields;

    assign in_run    = (state == S_RUN);
    assign pipe_busy = |p_vld;
    assign ld_acc    = in_run & bus.I_Ld_Req & ~bus.I_Ld_BTk.n;
    assign ld_oor    = ({1'b0, bus.I_Ld_Addr} >= DEPTH_X);
    // A load accepted in the same cycle counts as occupying the pipeline.
    assign boot_go   = bus.I_Boot_Start &
                       ((state == S_IDLE) | (in_run & ~pipe_busy & ~ld_acc));

    assign st_vld  = bus.I_St_Req & bus.I_St_FTk.v;
    assign st_nack = st_vld & (~in_run | ld_acc | bus.I_Pre_We);
    assign st_ok   = st_vld & ~st_nack;
    assign st_oor  = ({1'b0, bus.I_St_Addr} >= DEPTH_X);
    assign pre_oor = ({1'b0, bus.I_Pre_Addr} >= DEPTH_X);
    assign pre_wr  = bus.I_Pre_We & ~pre_oor;
    assign st_wr   = st_ok & ~st_oor;
    assign wr_idx  = pre_wr ? bus.I_Pre_Addr[AW-1:0] : bus.I_St_Addr[AW-1:0];
    assign wr_dat  = pre_wr ? bus.I_Pre_Data : bus.I_St_FTk.d;

    assign unused_fields = ^{bus.I_Ld_BTk.t, bus.I_Ld_BTk.v, bus.I_Ld_BTk.c,
                             bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c, bus.I_St_FTk.i};

    // Boot words are prefetched one cycle ahead so dq[0] holds mem[cnt] while in BOOT.
    always_comb begin
        rd_idx = bus.I_Ld_Addr[AW-1:0];
        if (state == S_PAD) begin
            rd_idx = '0;
        end else if (state == S_BOOT) begin
            rd_idx = AW'(cnt + XW'(1));
        end
    end

    always_comb begin
        tok_nxt = '0;
        case (state)
            S_PAD: begin
                tok_nxt.v = 1'b1;
                tok_nxt.a = (cnt == '0);
            end
            S_BOOT: begin
                tok_nxt.v = 1'b1;
                tok_nxt.d = dq[0];
                tok_nxt.i = EXTEND_MEM ? cnt : '0;
            end
            S_RUN: begin
                if (p_vld[L]) begin
                    tok_nxt.v = 1'b1;
                    tok_nxt.d = p_oor[L] ? '0 : dq[L];
                    tok_nxt.i = EXTEND_MEM ? p_addr[L] : '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        st_btk   = '0;
        st_btk.n = st_nack;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            p_vld <= '0;
            p_oor <= '0;
            tok   <= '0;
            err   <= 1'b0;
            for (int j = 0; j < RD_LAT; j++) begin
                p_addr[j] <= '0;
            end
        end else begin
            tok <= tok_nxt;
            err <= err | (ld_acc & ld_oor) | (st_ok & st_oor);

            case (state)
                S_IDLE: begin
                    if (boot_go) begin
                        state <= S_PAD;
                        cnt   <= '0;
                    end
                end
                S_PAD: begin
                    if (cnt == PAD_LAST) begin
                        state <= S_BOOT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + XW'(1);
                    end
                end
                S_BOOT: begin
                    if (cnt == BOOT_LAST) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + XW'(1);
                    end
                end
                default: begin
                    if (boot_go) begin
                        state <= S_PAD;
                        cnt   <= '0;
                    end
                end
            endcase

            p_vld[0]  <= ld_acc;
            p_oor[0]  <= ld_oor;
            p_addr[0] <= bus.I_Ld_Addr;
            for (int j = 1; j < RD_LAT; j++) begin
                p_vld[j]  <= p_vld[j-1];
                p_oor[j]  <= p_oor[j-1];
                p_addr[j] <= p_addr[j-1];
            end
        end
    end

    // Array and read-data pipeline carry no reset so the contents survive a reset.
    always_ff @(posedge clock) begin
        if (pre_wr | st_wr) begin
            mem[wr_idx] <= wr_dat;
        end
        dq[0] <= mem[rd_idx];
        for (int j = 1; j < RD_LAT; j++) begin
            dq[j] <= dq[j-1];
        end
    end

    assign bus.O_Boot   = (state == S_PAD) || (state == S_BOOT);
    assign bus.O_Ld_FTk = tok;
    assign bus.O_St_BTk = st_btk;
    assign bus.O_Err    = err;
endmodule

// File: doc/ext_mem_port.md
# ext_mem_port

Synthesizable, parametrised external-memory port for the ElectronNest top. It replaces the behavioural boot/load/store memory model used by benches. It holds program and data words in an internal array and runs the boot token sequence into `I_Ld_FTk`. It then serves load requests with configurable read latency and accepts stores through the token handshake, arbitrating a single memory port between them.

## Interface
- `DEPTH`, 1024: memory words. Addresses ≥ DEPTH are out of range.
- `BOOT_PAD`, 3: zero-data valid words emitted before the boot image.
- `BOOT_LEN`, 5: boot-image words, read from mem[0..BOOT_LEN-1].
- `RD_LAT`, 1: load latency in cycles, legal range 1..4.
- `EXTEND_MEM`, 0: when 1, load tokens carry the address in field `i`. When 0, `i` is driven 0.
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `I_Boot_Start`, in, 1: single-cycle boot request.
- `O_Boot`, out, 1: high while the boot sequence runs; drives the top's `I_Boot`.
- `I_Ld_Req`, in, 1: load request.
- `I_Ld_Addr`, in, WIDTH_EXADDR: load address.
- `O_Ld_FTk`, out, FTk_t: load/boot forward token.
- `I_Ld_BTk`, in, BTk_t: load back token; `n` blocks new load acceptance.
- `I_St_Req`, in, 1: store request.
- `I_St_Addr`, in, WIDTH_EXADDR: store address.
- `I_St_FTk`, in, FTk_t: store data token.
- `O_St_BTk`, out, BTk_t: store back token; only `n` is driven, all other fields are 0.
- `I_Pre_We`, in, 1: preload write strobe (bench/host).
- `I_Pre_Addr`, in, WIDTH_EXADDR: preload address.
- `I_Pre_Data`, in, WIDTH_DATA: preload data.
- `O_Err`, out, 1: sticky out-of-range flag, cleared only by reset.

## Operation
- FSM states: IDLE, PAD, BOOT, RUN.
  - IDLE → PAD on `I_Boot_Start`.
  - PAD lasts BOOT_PAD cycles, then → BOOT.
  - BOOT lasts BOOT_LEN cycles, then → RUN.
  - RUN → PAD on `I_Boot_Start` only when the load pipeline is empty; otherwise the start is ignored.
  - `I_Boot_Start` in PAD or BOOT is ignored.
- PAD tokens: v=1, d=0, i=0, r=0, c=0. a=1 on the first PAD word only.
- BOOT tokens: v=1, a=0, d=mem[k] for k=0..BOOT_LEN-1, i=k if EXTEND_MEM else 0.
- `O_Boot` is 1 in PAD and BOOT, and 0 otherwise.
- Loads are accepted in RUN only, when `ld_acc = I_Ld_Req & ~I_Ld_BTk.n`. Requests in other states are not accepted and are not queued.
- An accepted load emits after RD_LAT cycles: v=1, a=r=c=0, d=mem[addr], i=addr (EXTEND_MEM) or 0. When no load completes, v=0.
- In-flight loads always complete; `I_Ld_BTk.n` does not stall the pipeline.
- Store write condition: `st_ok = I_St_Req & I_St_FTk.v & ~O_St_BTk.n`. Data `I_St_FTk.d` is written at the clock edge.
- `O_St_BTk.n` (combinational) is 1 when:
  - `I_St_Req & I_St_FTk.v`, and
  - the state is not RUN, or `ld_acc` is true in the same cycle, or `I_Pre_We` is asserted.
- Port priority: preload > load > store. A nacked store must be held by the producer.
- Out of range (addr ≥ DEPTH):
  - Load returns d=0 and sets `O_Err`.
  - Store is acknowledged but dropped, and sets `O_Err`.
  - Preload is dropped and does not set `O_Err`.
- The memory array is not cleared by reset.

## Timing
- Reset values: `O_Boot`=0, `O_Ld_FTk`='0, `O_St_BTk`='0, `O_Err`=0. State is IDLE and the pipeline is empty.
- Reset asserted mid-boot or mid-load aborts immediately; in-flight loads are discarded.
- Boot start pulse at edge t → first PAD token visible after edge t+1. The last BOOT token is visible after edge t+BOOT_PAD+BOOT_LEN. Loads are accepted from the next cycle.
- Load accepted at edge t → token valid during the cycle after edge t+RD_LAT. Throughput is 1 load/cycle.
- Read-after-write: a store written at edge t is visible to a load accepted at edge t+1. A same-cycle store is nacked, so there is no hazard.
- Preload at edge t is visible to a load accepted at edge t+1.

## Test plan
- Boot with defaults: preload mem[0..4]=0x11..0x55, pulse start → 3 tokens d=0 (first a=1), then d=0x11..0x55, `O_Boot` high exactly 8 cycles, then RUN.
- Loads with RD_LAT=3, EXTEND_MEM=1: addresses 10, 11, 12 back-to-back → tokens with i=10..12 and d=mem[10..12] on 3 consecutive cycles, starting 3 cycles after the first accept.
- Conflict: a store to 20 and a load of 20 in the same cycle → store nacked, load returns old value. Store retried next cycle is written; a load the following cycle returns the new value.
- Backpressure: `I_Ld_BTk.n`=1 with `I_Ld_Req` held for 4 cycles → no accepts, `O_Ld_FTk.v` stays 0 once in-flight loads drain.
- Out of range: load 1025 → d=0, `O_Err`=1. Store 2000 → acknowledged, memory unchanged, `O_Err` stays 1 until reset.
- Reset during BOOT → all outputs 0 at once, state IDLE. A new start replays the full boot, and the memory contents are intact.
